hazard_scoreboard: RTL and testbench

- Parametrised successor to the pipeline hazard unit: replaces the fixed one-cycle load-use check with a per-register pending-write scoreboard.
- Each register carries a latency countdown, so results that take 1..MAX_LAT cycles to become forwardable are handled uniformly.
- Variable-latency results (mul/div, slow memory) are tracked with an explicit "unknown latency" tag and cleared by a completion strobe.
- Sits beside the forwarding logic; drives fetch/decode stall and decode/execute flush for the 5-stage in-order core.

---
 rtl/hazard_scoreboard.sv | 155 +++++++++++++++
 tb/tb_hazard_scoreboard.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// ============================================================================
//  Module   : hazard_scoreboard
//  Brief    : Per-register pending-write scoreboard for the 5-stage in-order
//             core. Tracks fixed-latency results with a countdown and
//             variable-latency results with an UNK tag cleared by done_vld.
//             Drives fetch/decode stall and decode/execute flush.
//  Options  : HZ_PERF_EN adds saturating performance counters
//             (perf_raw_cyc, perf_busy_cyc, perf_flush_cnt).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
    parameter int REG_AW = 5,
    parameter int LAT_W  = 3,
    parameter int PERF_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REG_AW-1:0]      rs1d,
    input  logic [REG_AW-1:0]      rs2d,
    input  logic                   rs1_used,
    input  logic                   rs2_used,
    input  logic [REG_AW-1:0]      rdd,
    input  logic                   regwrtd,
    input  logic [LAT_W-1:0]       latd,
    input  logic                   validd,
    input  logic                   pcsrce,
    input  logic                   busy,
    input  logic                   done_vld,
    input  logic [REG_AW-1:0]      done_rd,
    output logic                   stallf,
    output logic                   stalld,
    output logic                   flushd,
    output logic                   flushe,
    output logic [(2**REG_AW)-1:0] sb_pend
`ifdef HZ_PERF_EN
    ,
    output logic [PERF_W-1:0]      perf_raw_cyc,
    output logic [PERF_W-1:0]      perf_busy_cyc,
    output logic [PERF_W-1:0]      perf_flush_cnt
`endif
);

    localparam int               NREG  = 2**REG_AW;
    localparam logic [LAT_W-1:0] c_unk = '1;
    localparam logic [LAT_W-1:0] c_one = LAT_W'(1);

    logic [NREG-1:0]  r_pend;
    logic [LAT_W-1:0] r_cnt [NREG];
    logic [NREG-1:0]  w_pend_nxt;
    logic [LAT_W-1:0] w_cnt_nxt [NREG];

    logic w_raw;
    logic w_waw;
    logic w_hz;
    logic w_stall;
    logic w_issue;

    // Hazard detection against the current scoreboard contents
    always_comb begin
        w_raw = validd && ((rs1_used && (rs1d != '0) && r_pend[rs1d]) ||
                           (rs2_used && (rs2d != '0) && r_pend[rs2d]));
        // Only an UNK writer can be overtaken by a later fixed-latency write,
        // so a second writer must wait for its completion strobe.
        w_waw = validd && regwrtd && (rdd != '0) && r_pend[rdd] &&
                (r_cnt[rdd] == c_unk);
        w_hz    = w_raw || w_waw;
        w_stall = w_hz || busy;
        w_issue = validd && !w_stall && !pcsrce;
    end

    // Pipeline control; forced quiet while reset is asserted
    always_comb begin
        stallf = !rst && w_stall;
        stalld = !rst && w_stall;
        flushe = !rst && ((w_hz && !busy) || pcsrce);
        flushd = !rst && pcsrce;
    end

    // Next-state per entry: countdown, then completion, then issue (issue wins)
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            w_pend_nxt[i] = r_pend[i];
            w_cnt_nxt[i]  = r_cnt[i];
            if (r_pend[i] && (r_cnt[i] != '0) && (r_cnt[i] != c_unk)) begin
                w_cnt_nxt[i] = r_cnt[i] - c_one;
                if (r_cnt[i] == c_one) begin
                    w_pend_nxt[i] = 1'b0;
                end
            end
            if (done_vld && (done_rd == REG_AW'(i)) && (r_cnt[i] == c_unk)) begin
                w_pend_nxt[i] = 1'b0;
            end
            if (w_issue && regwrtd && (rdd == REG_AW'(i)) && (latd != '0)) begin
                w_pend_nxt[i] = 1'b1;
                w_cnt_nxt[i]  = latd;
            end
            // x0 is hard-wired and never tracked
            if (i == 0) begin
                w_pend_nxt[i] = 1'b0;
                w_cnt_nxt[i]  = '0;
            end
        end
    end

    // Scoreboard state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
            for (int i = 0; i < NREG; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_pend <= w_pend_nxt;
            for (int i = 0; i < NREG; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    assign sb_pend = r_pend;

`ifdef HZ_PERF_EN
    logic [PERF_W-1:0] r_perf_raw;
    logic [PERF_W-1:0] r_perf_busy;
    logic [PERF_W-1:0] r_perf_flush;

    // Saturating event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_raw   <= '0;
            r_perf_busy  <= '0;
            r_perf_flush <= '0;
        end else begin
            if (w_hz && !busy && (r_perf_raw != '1)) begin
                r_perf_raw <= r_perf_raw + PERF_W'(1);
            end
            if (busy && (r_perf_busy != '1)) begin
                r_perf_busy <= r_perf_busy + PERF_W'(1);
            end
            if (pcsrce && (r_perf_flush != '1)) begin
                r_perf_flush <= r_perf_flush + PERF_W'(1);
            end
        end
    end

    assign perf_raw_cyc   = r_perf_raw;
    assign perf_busy_cyc  = r_perf_busy;
    assign perf_flush_cnt = r_perf_flush;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
//  Module   : tb_hazard_scoreboard
//  Brief    : Directed scenarios plus randomized traffic for hazard_scoreboard,
//             checked against a ready-time reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

    typedef struct packed {
        logic       v;
        logic       r1u;
        logic       r2u;
        logic       wr;
        logic [4:0] a1;
        logic [4:0] a2;
        logic [4:0] d;
        logic [2:0] l;
        logic       bz;
        logic       pc;
        logic       dv;
        logic [4:0] dr;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1d, rs2d, rdd, done_rd;
    logic        rs1_used, rs2_used, regwrtd, validd, pcsrce, busy, done_vld;
    logic [2:0]  latd;
    logic        stallf, stalld, flushd, flushe;
    logic [31:0] sb_pend;
`ifdef HZ_PERF_EN
    logic [31:0] perf_raw_cyc, perf_busy_cyc, perf_flush_cnt;
`endif

    hazard_scoreboard dut (
        .clk      (clk),
        .rst      (rst),
        .rs1d     (rs1d),
        .rs2d     (rs2d),
        .rs1_used (rs1_used),
        .rs2_used (rs2_used),
        .rdd      (rdd),
        .regwrtd  (regwrtd),
        .latd     (latd),
        .validd   (validd),
        .pcsrce   (pcsrce),
        .busy     (busy),
        .done_vld (done_vld),
        .done_rd  (done_rd),
        .stallf   (stallf),
        .stalld   (stalld),
        .flushd   (flushd),
        .flushe   (flushe),
        .sb_pend  (sb_pend)
`ifdef HZ_PERF_EN
        ,
        .perf_raw_cyc   (perf_raw_cyc),
        .perf_busy_cyc  (perf_busy_cyc),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a register is pending while an UNK result is
    // outstanding or until the absolute edge number at which it is ready.
    int   edge_n = 0;
    int   m_ready [32];
    logic m_unk   [32];
    int   m_raw_cnt, m_busy_cnt, m_flush_cnt;

    logic        last_stall, last_flushe, last_flushd;
    logic [31:0] last_pend;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic logic m_is_pend(input logic [4:0] r);
        return (r != 5'd0) && (m_unk[r] || (edge_n < m_ready[r]));
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_ready[r] = 0;
            m_unk[r]   = 1'b0;
        end
        m_raw_cnt = 0;
        m_busy_cnt = 0;
        m_flush_cnt = 0;
    endtask

    task automatic drive(input stim_t s);
        validd = s.v;  rs1_used = s.r1u; rs2_used = s.r2u; regwrtd = s.wr;
        rs1d = s.a1;   rs2d = s.a2;      rdd = s.d;        latd = s.l;
        busy = s.bz;   pcsrce = s.pc;    done_vld = s.dv;  done_rd = s.dr;
    endtask

    // One clock cycle: apply stimulus, compare against the model, advance
    task automatic step(input stim_t s);
        logic        raw, waw, hz, issue;
        logic [31:0] exp_pend;
        @(negedge clk);
        drive(s);
        #1;
        for (int r = 0; r < 32; r++) exp_pend[r] = m_is_pend(5'(r));
        raw = s.v && ((s.r1u && m_is_pend(s.a1)) || (s.r2u && m_is_pend(s.a2)));
        waw = s.v && s.wr && (s.d != 5'd0) && m_unk[s.d];
        hz  = raw || waw;
        check_val("sb_pend", 64'(sb_pend), 64'(exp_pend));
        check_val("stallf", 64'(stallf), 64'(hz || s.bz));
        check_val("stalld", 64'(stalld), 64'(hz || s.bz));
        check_val("flushe", 64'(flushe), 64'((hz && !s.bz) || s.pc));
        check_val("flushd", 64'(flushd), 64'(s.pc));
        last_stall = stalld; last_flushe = flushe; last_flushd = flushd; last_pend = sb_pend;
        issue = s.v && !(hz || s.bz) && !s.pc;
        if (hz && !s.bz) m_raw_cnt++;
        if (s.bz)        m_busy_cnt++;
        if (s.pc)        m_flush_cnt++;
        @(posedge clk);
        edge_n++;
        if (s.dv && (s.dr != 5'd0) && m_unk[s.dr]) begin
            m_unk[s.dr]   = 1'b0;
            m_ready[s.dr] = 0;
        end
        if (issue && s.wr && (s.d != 5'd0) && (s.l != 3'd0)) begin
            if (s.l == 3'd7) begin
                m_unk[s.d]   = 1'b1;
                m_ready[s.d] = 0;
            end else begin
                m_unk[s.d]   = 1'b0;
                m_ready[s.d] = edge_n + int'(s.l);
            end
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(idle());
    endtask

    // Repeats a stimulus until decode stops stalling; returns stall cycles
    task automatic count_stalls(input stim_t s, output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step(s);
            if (!last_stall) break;
            n++;
        end
    endtask

    initial begin
        stim_t s;
        int    n;

        model_reset();
        drive(idle());
        pcsrce = 1'b1;
        busy   = 1'b1;
        rst    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_pend", 64'(sb_pend), 64'd0);
        check_val("rst_stall", 64'(stallf), 64'd0);
        check_val("rst_flush", 64'({flushd, flushe}), 64'd0);
        @(negedge clk);
        drive(idle());
        rst = 1'b0;

        // Load-use: exactly one bubble
        s = idle(); s.v = 1; s.wr = 1; s.d = 5'd5; s.l = 3'd1;
        step(s);
        s = idle(); s.v = 1; s.r1u = 1; s.a1 = 5'd5;
        count_stalls(s, n);
        check_val("loaduse_stalls", 64'(n), 64'd1);
        check_val("loaduse_pend5", 64'(last_pend[5]), 64'd0);

        // Latency 3: three stall cycles
        s = idle(); s.v = 1; s.wr = 1; s.d = 5'd7; s.l = 3'd3;
        step(s);
        s = idle(); s.v = 1; s.r2u = 1; s.a2 = 5'd7;
        count_stalls(s, n);
        check_val("lat3_stalls", 64'(n), 64'd3);

        // Unknown latency released by done, then write-after-write
        s = idle(); s.v = 1; s.wr = 1; s.d = 5'd9; s.l = 3'd7;
        step(s);
        s = idle(); s.v = 1; s.r1u = 1; s.a1 = 5'd9;
        n = 0;
        for (int i = 0; i < 9; i++) begin
            step(s);
            if (last_stall) n++;
        end
        check_val("unk_stalls", 64'(n), 64'd9);
        s.dv = 1; s.dr = 5'd9;
        step(s);
        check_val("unk_done_cycle", 64'(last_stall), 64'd1);
        s.dv = 0;
        step(s);
        check_val("unk_released", 64'(last_stall), 64'd0);
        s = idle(); s.v = 1; s.wr = 1; s.d = 5'd9; s.l = 3'd7;
        step(s);
        s.l = 3'd2;
        step(s);
        check_val("waw_stall", 64'(last_stall), 64'd1);
        s.dv = 1; s.dr = 5'd9;
        step(s);
        s.dv = 0;
        step(s);
        check_val("waw_released", 64'(last_stall), 64'd0);
        drain(3);

        // Redirect suppresses issue; older entry keeps counting
        s = idle(); s.v = 1; s.wr = 1; s.d = 5'd4; s.l = 3'd2;
        step(s);
        s = idle(); s.v = 1; s.wr = 1; s.d = 5'd3; s.l = 3'd1; s.pc = 1;
        step(s);
        check_val("redir_flush", 64'({last_flushd, last_flushe}), 64'h3);
        step(idle());
        check_val("redir_pend3", 64'(last_pend[3]), 64'd0);
        check_val("redir_pend4", 64'(last_pend[4]), 64'd1);
        step(idle());
        check_val("redir_pend4_exp", 64'(last_pend[4]), 64'd0);

        // busy overlapping a pending RAW: no bubble, no issue
        s = idle(); s.v = 1; s.wr = 1; s.d = 5'd6; s.l = 3'd2;
        step(s);
        s = idle(); s.v = 1; s.r1u = 1; s.a1 = 5'd6; s.wr = 1; s.d = 5'd10; s.l = 3'd1; s.bz = 1;
        for (int i = 0; i < 4; i++) begin
            step(s);
            check_val("busy_flushe", 64'(last_flushe), 64'd0);
        end
        step(idle());
        check_val("busy_no_issue", 64'(last_pend[10]), 64'd0);

        // Asynchronous reset between edges
        s = idle(); s.v = 1; s.wr = 1; s.d = 5'd5; s.l = 3'd5;
        step(s);
        s.d = 5'd9; s.l = 3'd7;
        step(s);
        #1;
        check_val("pre_rst_pend", 64'({sb_pend[9], sb_pend[5]}), 64'h3);
        @(negedge clk);
        s = idle(); s.v = 1; s.r1u = 1; s.a1 = 5'd9; s.bz = 1; s.pc = 1;
        drive(s);
        #2 rst = 1'b1;
        #1;
        check_val("arst_pend", 64'(sb_pend), 64'd0);
        check_val("arst_ctl", 64'({stallf, stalld, flushd, flushe}), 64'd0);
`ifdef HZ_PERF_EN
        check_val("arst_perf", 64'(perf_raw_cyc | perf_busy_cyc | perf_flush_cnt), 64'd0);
`endif
        #1;
        drive(idle());
        rst = 1'b0;
        model_reset();

        // Randomized traffic over a small register window to force collisions
        for (int i = 0; i < 2000; i++) begin
            s = idle();
            s.v   = ($urandom_range(0, 3) != 0);
            s.r1u = $urandom_range(0, 1);
            s.r2u = $urandom_range(0, 1);
            s.wr  = $urandom_range(0, 1);
            s.a1  = 5'($urandom_range(0, 7));
            s.a2  = 5'($urandom_range(0, 7));
            s.d   = 5'($urandom_range(0, 7));
            s.l   = 3'($urandom_range(0, 7));
            s.bz  = ($urandom_range(0, 7) == 0);
            s.pc  = ($urandom_range(0, 7) == 0);
            s.dv  = ($urandom_range(0, 3) == 0);
            s.dr  = 5'($urandom_range(0, 7));
            step(s);
        end

`ifdef HZ_PERF_EN
        #1;
        check_val("perf_raw", 64'(perf_raw_cyc), 64'(m_raw_cnt));
        check_val("perf_busy", 64'(perf_busy_cyc), 64'(m_busy_cnt));
        check_val("perf_flush", 64'(perf_flush_cnt), 64'(m_flush_cnt));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
